slave_rsp_mux: RTL and testbench
================================

Name: slave_rsp_mux

Overview:
- Return-path counterpart of the slave-select decoder.
- Latches the selected slave index when the request phase starts.
- Routes only that slave's ready and serial read-data signals back to the master side, and ignores the other two slaves.
- Ends each transaction on completion, on a response timeout, or on an invalid select; sits between the three slave ports and the master interface.

Parameters:
DATA_WIDTH, 8, number of serial read-data beats per read transaction
TIMEOUT, 255, max consecutive cycles without slave progress before error (>=2)
CNT_W, $clog2(DATA_WIDTH), bit-count width (derived, do not override)
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request phase begins; same qualifier as decoder enable
sel  in  2  slave index: 00=slave1, 01=slave2, 10=slave3, 11=invalid
is_read  in  1  1=read transaction, 0=write; sampled with start
s1_ready, s2_ready, s3_ready  in  1 each  slave accepted/completed request
s1_rdata, s2_rdata, s3_rdata  in  1 each  slave serial read-data bit
s1_rvalid, s2_rvalid, s3_rvalid  in  1 each  rdata bit valid
m_ready  out  1  one-cycle pulse: transaction complete
m_rdata  out  1  registered serial read bit to master
m_rvalid  out  1  registered read bit valid
m_err  out  1  one-cycle pulse: timeout or invalid select
busy  out  1  transaction in progress

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; sel_q, rd_q, bit_cnt and to_cnt cleared.
  - All outputs 0.
  - Applies mid-transaction with no completion or error pulse emitted.
- All outputs are registered; busy=1 in every state except IDLE.
- States: IDLE, WAIT, READ, ERR.
- IDLE:
  - start=1 latches sel->sel_q and is_read->rd_q, and clears to_cnt and bit_cnt.
  - Next state is ERR if sel=11, otherwise WAIT.
  - start=0: stay in IDLE.
- ERR:
  - m_err=1 for exactly one cycle, then IDLE.
  - Slave inputs are ignored throughout.
- WAIT (sample the selected slave's ready, rdy):
  - rdy=1 and rd_q=0: m_ready pulses next cycle, then IDLE.
  - rdy=1 and rd_q=1: go to READ, clear to_cnt.
  - rdy=0: increment to_cnt. When to_cnt reaches TIMEOUT-1, go to ERR so m_err pulses; m_ready stays 0.
  - rvalid while in WAIT is ignored.
- READ (per cycle the selected slave's rvalid=1):
  - Next cycle: m_rvalid=1 and m_rdata=the sampled bit. Latency is exactly 1 cycle.
  - Increment bit_cnt and clear to_cnt.
  - On the beat with bit_cnt=DATA_WIDTH-1: m_ready=1 in the same output cycle as the last m_rvalid, then IDLE.
  - rvalid=0: m_rvalid=0 and to_cnt increments; timeout behaves as in WAIT.
- Boundary rules:
  - Slave progress (ready/rvalid) in the same cycle as the timeout threshold: progress wins, no error.
  - start while busy=1 is ignored; sel and is_read are not re-sampled.
  - Inputs of non-selected slaves never affect outputs, including glitching ready/rvalid.
  - m_rdata holds its last value when m_rvalid=0 and is 0 after reset.
  - start in the same cycle the FSM returns to IDLE is not accepted until the state is IDLE.
  - m_ready and m_err are never asserted together.

Decomposition:
- Shared bus package holds:
  - slave index constants SEL_S1=2'b00, SEL_S2=2'b01, SEL_S3=2'b10, SEL_INV=2'b11;
  - state encoding localparams for IDLE/WAIT/READ/ERR;
  - default DATA_WIDTH and TIMEOUT.
- One natural sub-module, slave_rsp_sel: combinational 3:1 selection of {ready, rdata, rvalid} by sel_q.
- FSM, counters and output registers stay in slave_rsp_mux.

Test Plan:
1. Write to slave2:
   - Stimulus: start=1, sel=01, is_read=0; s2_ready=1 three cycles later.
   - Response: m_ready pulses exactly one cycle after s2_ready; busy deasserts that cycle; m_err=0.
2. Read from slave3, DATA_WIDTH=8:
   - Stimulus: s3_ready, then rvalid beats carrying 0xA5 MSB-first with one idle gap; s1/s2 toggle randomly.
   - Response: m_rvalid beats reproduce 1,0,1,0,0,1,0,1 with 1-cycle latency; m_ready coincides with the 8th m_rvalid.
3. Invalid select:
   - Stimulus: start=1, sel=11.
   - Response: m_err pulses for one cycle two cycles after start; back in IDLE; no m_ready.
4. Timeout, TIMEOUT=4:
   - Stimulus: select slave1 and never assert s1_ready.
   - Response: m_err pulses once after 4 WAIT cycles.
   - Repeat with s1_ready arriving on the threshold cycle: m_ready, no m_err.
5. Reset mid-read:
   - Stimulus: assert rst after 3 of 8 beats.
   - Response: all outputs 0 on the next edge; a new start is accepted normally after rst falls.
6. start while busy:
   - Stimulus: pulse start with sel=00 during a slave2 read.
   - Response: the read completes from slave2 only; the second request is dropped.

Source files
------------

// File: rtl/slave_rsp_mux_pkg.sv
// Shared definitions for the slave response return path: slave indices,
// FSM state encoding, default sizing and the per-slave response bundle.
package slave_rsp_mux_pkg;

  localparam logic [1:0] SEL_S1  = 2'b00;
  localparam logic [1:0] SEL_S2  = 2'b01;
  localparam logic [1:0] SEL_S3  = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_WAIT_ENC = 2'd1;
  localparam logic [1:0] ST_READ_ENC = 2'd2;
  localparam logic [1:0] ST_ERR_ENC  = 2'd3;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_READ = ST_READ_ENC,
    ST_ERR  = ST_ERR_ENC
  } state_t;

  typedef struct packed {
    logic ready;
    logic rdata;
    logic rvalid;
  } slv_rsp_t;

endpackage

// File: rtl/slave_rsp_sel.sv
// Combinational 3:1 pick of the latched slave's response; the invalid index
// yields an all-zero bundle so nothing leaks through from any slave.
module slave_rsp_sel
  import slave_rsp_mux_pkg::*;
(
  input  logic [1:0] sel,
  input  slv_rsp_t   s1,
  input  slv_rsp_t   s2,
  input  slv_rsp_t   s3,
  output slv_rsp_t   rsp_c
);

  always_comb begin
    rsp_c = '0;
    case (sel)
      SEL_S1:  rsp_c = s1;
      SEL_S2:  rsp_c = s2;
      SEL_S3:  rsp_c = s3;
      default: rsp_c = '0;
    endcase
  end

endmodule

// File: rtl/slave_rsp_mux.sv
// Return-path mux: latches the slave index at request start, forwards only
// that slave's ready/serial read data, and ends on completion, timeout or bad select.
module slave_rsp_mux
  import slave_rsp_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       is_read,
  input  logic       s1_ready,
  input  logic       s2_ready,
  input  logic       s3_ready,
  input  logic       s1_rdata,
  input  logic       s2_rdata,
  input  logic       s3_rdata,
  input  logic       s1_rvalid,
  input  logic       s2_rvalid,
  input  logic       s3_rvalid,
  output logic       m_ready,
  output logic       m_rdata,
  output logic       m_rvalid,
  output logic       m_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       sel_q;
  logic             rd_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  slv_rsp_t         rsp_c;

  slave_rsp_sel u_sel (
    .sel   (sel_q),
    .s1    ('{ready: s1_ready, rdata: s1_rdata, rvalid: s1_rvalid}),
    .s2    ('{ready: s2_ready, rdata: s2_rdata, rvalid: s2_rvalid}),
    .s3    ('{ready: s3_ready, rdata: s3_rdata, rvalid: s3_rvalid}),
    .rsp_c (rsp_c)
  );

  // FSM, counters and registered master-side outputs. Pulses default low
  // each cycle; m_rdata holds its last beat until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      rd_q     <= 1'b0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= 1'b0;
      m_rvalid <= 1'b0;
      m_err    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      m_ready  <= 1'b0;
      m_rvalid <= 1'b0;
      m_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q   <= sel;
            rd_q    <= is_read;
            to_cnt  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= (sel == SEL_INV) ? ST_ERR : ST_WAIT;
          end
        end
        // Progress is tested before the threshold so it wins a tie.
        ST_WAIT: begin
          if (rsp_c.ready) begin
            if (rd_q) begin
              to_cnt <= '0;
              state  <= ST_READ;
            end else begin
              m_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_READ: begin
          if (rsp_c.rvalid) begin
            m_rvalid <= 1'b1;
            m_rdata  <= rsp_c.rdata;
            to_cnt   <= '0;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              m_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_ERR: begin
          m_err <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_rsp_mux.sv
// Directed bench for slave_rsp_mux: expected master-side events are queued as
// stimulus is driven and matched by a negedge monitor; timing checked inline.
module tb_slave_rsp_mux;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  typedef struct packed {
    logic ready;
    logic rvalid;
    logic rdata;
    logic err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       is_read = 1'b0;
  logic       s1_ready = 1'b0, s2_ready = 1'b0, s3_ready = 1'b0;
  logic       s1_rdata = 1'b0, s2_rdata = 1'b0, s3_rdata = 1'b0;
  logic       s1_rvalid = 1'b0, s2_rvalid = 1'b0, s3_rvalid = 1'b0;
  logic       m_ready, m_rdata, m_rvalid, m_err, busy;

  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  logic [2:0] noise = 3'b000;

  slave_rsp_mux #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .is_read(is_read),
    .s1_ready(s1_ready), .s2_ready(s2_ready), .s3_ready(s3_ready),
    .s1_rdata(s1_rdata), .s2_rdata(s2_rdata), .s3_rdata(s3_rdata),
    .s1_rvalid(s1_rvalid), .s2_rvalid(s2_rvalid), .s3_rvalid(s3_rvalid),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_err(m_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic v, input logic d, input logic e);
    exp_q.push_back({r, v, d, e});
  endtask

  // Advance one clock; non-selected slaves get fresh random values.
  task automatic tick();
    @(posedge clk);
    #1;
    if (noise[0]) {s1_ready, s1_rdata, s1_rvalid} = 3'($urandom);
    if (noise[1]) {s2_ready, s2_rdata, s2_rvalid} = 3'($urandom);
    if (noise[2]) {s3_ready, s3_rdata, s3_rvalid} = 3'($urandom);
  endtask

  task automatic quiet();
    noise = 3'b000;
    {s1_ready, s1_rdata, s1_rvalid} = 3'b000;
    {s2_ready, s2_rdata, s2_rvalid} = 3'b000;
    {s3_ready, s3_rdata, s3_rvalid} = 3'b000;
  endtask

  // Scoreboard: every master-side event must match the next queued one.
  always @(negedge clk) begin
    ev_t obs;
    ev_t want;
    if (m_ready | m_rvalid | m_err) begin
      obs = {m_ready, m_rvalid, m_rvalid & m_rdata, m_err};
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 8'(obs), 8'(0));
      end else begin
        want = exp_q.pop_front();
        chk("event", 8'(obs), 8'(want));
      end
    end
  end

  initial begin
    logic [7:0] rd_a5;
    logic [7:0] rd_3c;
    rd_a5 = 8'hA5;
    rd_3c = 8'h3C;

    // Reset state
    tick(); tick();
    chk("rst_busy", 8'(busy), 8'(0));
    chk("rst_m_ready", 8'(m_ready), 8'(0));
    chk("rst_m_rvalid", 8'(m_rvalid), 8'(0));
    chk("rst_m_rdata", 8'(m_rdata), 8'(0));
    chk("rst_m_err", 8'(m_err), 8'(0));
    rst = 1'b0;
    tick();

    // 1: write to slave2, ready three cycles after start
    noise = 3'b101;
    start = 1'b1; sel = 2'b01; is_read = 1'b0;
    tick();
    start = 1'b0;
    chk("wr_busy", 8'(busy), 8'(1));
    tick(); tick();
    s2_ready = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s2_ready = 1'b0;
    chk("wr_m_ready", 8'(m_ready), 8'(1));
    chk("wr_busy_done", 8'(busy), 8'(0));
    chk("wr_m_err", 8'(m_err), 8'(0));
    tick();
    chk("wr_ready_pulse", 8'(m_ready), 8'(0));
    quiet();

    // 2: read 0xA5 from slave3 with one idle gap, slaves 1/2 glitching
    noise = 3'b011;
    start = 1'b1; sel = 2'b10; is_read = 1'b1;
    tick();
    start = 1'b0;
    s3_ready = 1'b1;
    tick();
    s3_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        s3_rvalid = 1'b0;
        tick();
        chk("rd_gap_rvalid", 8'(m_rvalid), 8'(0));
        chk("rd_gap_hold", 8'(m_rdata), 8'(rd_a5[5]));
      end
      s3_rvalid = 1'b1;
      s3_rdata  = rd_a5[7-i];
      push(i == 7, 1'b1, rd_a5[7-i], 1'b0);
      tick();
      chk("rd_beat_rvalid", 8'(m_rvalid), 8'(1));
      chk("rd_beat_data", 8'(m_rdata), 8'(rd_a5[7-i]));
      chk("rd_beat_ready", 8'(m_ready), 8'(i == 7));
    end
    s3_rvalid = 1'b0;
    tick();
    chk("rd_end_busy", 8'(busy), 8'(0));
    chk("rd_end_hold", 8'(m_rdata), 8'(1));
    quiet();

    // 3: invalid select, all slaves glitching
    noise = 3'b111;
    start = 1'b1; sel = 2'b11; is_read = 1'b0;
    tick();
    start = 1'b0;
    chk("inv_busy", 8'(busy), 8'(1));
    chk("inv_err_early", 8'(m_err), 8'(0));
    push(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("inv_err", 8'(m_err), 8'(1));
    chk("inv_no_ready", 8'(m_ready), 8'(0));
    chk("inv_busy_done", 8'(busy), 8'(0));
    tick();
    chk("inv_err_pulse", 8'(m_err), 8'(0));
    quiet();

    // 4a: slave1 never ready -> timeout after TO wait cycles
    noise = 3'b110;
    start = 1'b1; sel = 2'b00; is_read = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("to_err_early", 8'(m_err), 8'(0));
    chk("to_busy", 8'(busy), 8'(1));
    push(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("to_err", 8'(m_err), 8'(1));
    chk("to_busy_done", 8'(busy), 8'(0));
    tick();
    chk("to_err_pulse", 8'(m_err), 8'(0));

    // 4b: ready on the threshold cycle wins
    start = 1'b1; sel = 2'b00; is_read = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    s1_ready = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s1_ready = 1'b0;
    chk("thr_ready", 8'(m_ready), 8'(1));
    chk("thr_no_err", 8'(m_err), 8'(0));
    tick();
    chk("thr_no_late_err", 8'(m_err), 8'(0));
    quiet();

    // 5: reset after 3 of 8 beats, then a fresh write is accepted
    noise = 3'b110;
    start = 1'b1; sel = 2'b00; is_read = 1'b1;
    tick();
    start = 1'b0;
    s1_ready = 1'b1;
    tick();
    s1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s1_rvalid = 1'b1; s1_rdata = 1'b1;
      push(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", 8'(m_rvalid), 8'(0));
    chk("mid_rst_rdata", 8'(m_rdata), 8'(0));
    chk("mid_rst_busy", 8'(busy), 8'(0));
    chk("mid_rst_ready", 8'(m_ready), 8'(0));
    chk("mid_rst_err", 8'(m_err), 8'(0));
    rst = 1'b0;
    quiet();
    noise = 3'b101;
    start = 1'b1; sel = 2'b01; is_read = 1'b0;
    tick();
    start = 1'b0;
    chk("post_rst_busy", 8'(busy), 8'(1));
    s2_ready = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    s2_ready = 1'b0;
    chk("post_rst_ready", 8'(m_ready), 8'(1));
    quiet();

    // 6: start pulses while reading slave2 (mid-read and on the last beat)
    noise = 3'b100;
    s1_ready = 1'b1; s1_rvalid = 1'b1; s1_rdata = 1'b0;
    start = 1'b1; sel = 2'b01; is_read = 1'b1;
    tick();
    start = 1'b0;
    s2_ready = 1'b1;
    tick();
    s2_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s2_rvalid = 1'b1;
      s2_rdata  = rd_3c[7-i];
      start = (i == 2) || (i == 7);
      sel = 2'b00; is_read = 1'b0;
      push(i == 7, 1'b1, rd_3c[7-i], 1'b0);
      tick();
      start = 1'b0;
      chk("busy_rd_data", 8'(m_rdata), 8'(rd_3c[7-i]));
    end
    s2_rvalid = 1'b0;
    chk("busy_rd_done", 8'(busy), 8'(0));
    tick();
    chk("busy_drop_idle", 8'(busy), 8'(0));
    tick(); tick();
    chk("busy_drop_no_ready", 8'(m_ready), 8'(0));
    quiet();

    tick(); tick();
    chk("queue_drained", 8'(exp_q.size()), 8'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
